// File: rtl/test_mailbox_pkg.sv
// Shared types and constants for the test mailbox: FSM states, register
// offsets and the byte-enable merge helper.
package test_mailbox_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE,
      ST_TIMEOUT
   } state_e;

   localparam logic [1:0]  REG_FLAG   = 2'd0;
   localparam logic [1:0]  REG_RESULT = 2'd1;
   localparam logic [1:0]  REG_CYCLES = 2'd2;
   localparam logic [1:0]  REG_ID     = 2'd3;

   localparam logic [31:0] DEFAULT_MAILBOX_ID = 32'hCE5E_0001;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_val;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/mailbox_cycle_counter.sv
// Saturating 32-bit cycle counter with synchronous clear (priority) and
// count enable; holds its value when neither is asserted.
module mailbox_cycle_counter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        en_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/test_mailbox.sv
// Test-completion mailbox: small register file on the core data bus plus a
// run/done/timeout FSM that records whether RESULT matched the golden value.
module test_mailbox
   import test_mailbox_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000,
   parameter logic [31:0] MAILBOX_ID     = DEFAULT_MAILBOX_ID
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        req_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        err_o,
   input  logic [31:0] expected_i,
   output logic        done_o,
   output logic        pass_o,
   output logic        timeout_o,
   output logic [31:0] result_o,
   output logic [31:0] cycles_o
);

   localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

   state_e      state_q, state_d;
   logic [31:0] flag_q, flag_d;
   logic [31:0] result_q, result_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        timeout_q, timeout_d;
   logic        rvalid_q, rvalid_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic        cnt_clear;
   logic        cnt_en;
   logic [31:0] cycles;
   logic [1:0]  reg_sel;
   logic        wr;
   logic        writable;
   logic [31:0] flag_merged;
   logic        unused_addr;

   assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};
   assign reg_sel     = addr_i[3:2];
   assign wr          = req_i & we_i;
   assign writable    = (state_q == ST_IDLE) || (state_q == ST_RUN);
   assign flag_merged = merge_bytes(flag_q, wdata_i, be_i);

   mailbox_cycle_counter u_cycle_counter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (cnt_clear),
      .en_i    (cnt_en),
      .count_o (cycles)
   );

   always_comb begin
      state_d   = state_q;
      flag_d    = flag_q;
      result_d  = result_q;
      done_d    = done_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      rvalid_d  = req_i;
      err_d     = 1'b0;
      rdata_d   = '0;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;

      if (req_i) begin
         case (reg_sel)
            REG_FLAG:   rdata_d = flag_q;
            REG_RESULT: rdata_d = result_q;
            REG_CYCLES: rdata_d = cycles;
            default:    rdata_d = MAILBOX_ID;
         endcase
      end

      if (wr && ((reg_sel == REG_CYCLES) || (reg_sel == REG_ID))) err_d = 1'b1;

      if (wr && writable) begin
         if (reg_sel == REG_FLAG)   flag_d   = flag_merged;
         if (reg_sel == REG_RESULT) result_d = merge_bytes(result_q, wdata_i, be_i);
      end

      // The counter only advances while staying in RUN, so it freezes on the exit cycle.
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d   = ST_RUN;
               cnt_clear = 1'b1;
            end
         end
         ST_RUN: begin
            if (wr && (reg_sel == REG_FLAG) && (flag_merged != '0)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               pass_d  = (result_q == expected_i);
            end else if (cycles == TIMEOUT_LAST) begin
               state_d   = ST_TIMEOUT;
               timeout_d = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         flag_q    <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         flag_q    <= flag_d;
         result_q  <= result_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   // Outputs are masked by rst_i so a response pending at reset assertion is never seen.
   assign gnt_o     = req_i;
   assign rvalid_o  = rvalid_q  & ~rst_i;
   assign err_o     = err_q     & ~rst_i;
   assign rdata_o   = rst_i ? '0 : rdata_q;
   assign done_o    = done_q    & ~rst_i;
   assign pass_o    = pass_q    & ~rst_i;
   assign timeout_o = timeout_q & ~rst_i;
   assign result_o  = rst_i ? '0 : result_q;
   assign cycles_o  = rst_i ? '0 : cycles;

endmodule

// File: tb/tb_test_mailbox.sv
// Directed bench for test_mailbox: a vector table for single-cycle bus and
// FSM behaviour, plus hand sequences for timeout, simultaneity and reset.
module tb_test_mailbox;

   localparam logic [31:0] ID_VAL = 32'hCE5E_0001;
   localparam logic [31:0] R5050  = 32'd5050;
   localparam logic [31:0] R5049  = 32'd5049;
   localparam logic [31:0] BBDD   = 32'h00BB_00DD;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1, start_i = 1'b0, req_i = 1'b0, we_i = 1'b0;
   logic [3:0]  be_i = '0;
   logic [31:0] addr_i = '0, wdata_i = '0, expected_i = '0;
   logic        gnt_o, rvalid_o, err_o, done_o, pass_o, timeout_o;
   logic [31:0] rdata_o, result_o, cycles_o;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   test_mailbox #(.TIMEOUT_CYCLES(32'd16)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .req_i(req_i),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o), .we_i(we_i), .be_i(be_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .err_o(err_o),
      .expected_i(expected_i), .done_o(done_o), .pass_o(pass_o),
      .timeout_o(timeout_o), .result_o(result_o), .cycles_o(cycles_o)
   );

   typedef struct {
      logic        rst, start, req, we;
      logic [3:0]  be;
      logic [31:0] addr, wdata, expected;
      logic        rvalid, err;
      logic [31:0] rdata;
      logic        done, pass, timeout;
      logic [31:0] result, cycles;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, start, req, we, input logic [3:0] be,
                               input logic [31:0] addr, wdata, expected,
                               input logic rvalid, err, input logic [31:0] rdata,
                               input logic done, pass, timeout,
                               input logic [31:0] result, cycles);
      vec_t v;
      v.rst = rst; v.start = start; v.req = req; v.we = we; v.be = be;
      v.addr = addr; v.wdata = wdata; v.expected = expected;
      v.rvalid = rvalid; v.err = err; v.rdata = rdata;
      v.done = done; v.pass = pass; v.timeout = timeout;
      v.result = result; v.cycles = cycles;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input logic rst, start, req, we, input logic [3:0] be,
                        input logic [31:0] addr, wdata, expected);
      @(negedge clk);
      rst_i = rst; start_i = start; req_i = req; we_i = we; be_i = be;
      addr_i = addr; wdata_i = wdata; expected_i = expected;
      #1;
      chk("gnt", {31'd0, gnt_o}, {31'd0, req});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      tick();
   endtask

   task automatic do_reset();
      apply(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //            rst st req we be     addr   wdata         exp     rv er rdata   dn ps to result cycles
      vecs.push_back(mk(1,0,0,0,4'h0,32'h0,32'h0,        32'h0, 0,0,32'h0, 0,0,0,32'h0,32'd0));
      vecs.push_back(mk(0,0,1,0,4'h0,32'hC,32'h0,        32'h0, 1,0,ID_VAL,0,0,0,32'h0,32'd0));
      vecs.push_back(mk(0,0,1,1,4'h5,32'h4,32'hAABBCCDD, 32'h0, 1,0,32'h0, 0,0,0,BBDD, 32'd0));
      vecs.push_back(mk(0,0,1,0,4'h0,32'h4,32'h0,        32'h0, 1,0,BBDD,  0,0,0,BBDD, 32'd0));
      vecs.push_back(mk(0,0,1,1,4'hF,32'h8,32'h1234,     32'h0, 1,1,32'h0, 0,0,0,BBDD, 32'd0));
      vecs.push_back(mk(0,0,1,1,4'hF,32'h0,32'h1,        32'h0, 1,0,32'h0, 0,0,0,BBDD, 32'd0));
      vecs.push_back(mk(0,0,1,0,4'h0,32'h0,32'h0,        32'h0, 1,0,32'h1, 0,0,0,BBDD, 32'd0));
      vecs.push_back(mk(0,1,0,0,4'h0,32'h0,32'h0,        32'h0, 0,0,32'h0, 0,0,0,BBDD, 32'd0));
      vecs.push_back(mk(0,0,1,1,4'hF,32'h4,R5050,        32'h0, 1,0,BBDD,  0,0,0,R5050,32'd1));
      vecs.push_back(mk(0,0,1,1,4'hF,32'h0,32'h1,        R5050, 1,0,32'h1, 1,1,0,R5050,32'd1));
      vecs.push_back(mk(0,0,0,0,4'h0,32'h0,32'h0,        R5050, 0,0,32'h0, 1,1,0,R5050,32'd1));
      vecs.push_back(mk(0,0,1,1,4'hF,32'h4,32'd1234,     R5050, 1,0,R5050, 1,1,0,R5050,32'd1));
      vecs.push_back(mk(0,0,1,0,4'h0,32'h8,32'h0,        R5050, 1,0,32'h1, 1,1,0,R5050,32'd1));
      vecs.push_back(mk(1,0,1,0,4'h0,32'hC,32'h0,        32'h0, 0,0,32'h0, 0,0,0,32'h0,32'd0));
      vecs.push_back(mk(0,1,0,0,4'h0,32'h0,32'h0,        32'h0, 0,0,32'h0, 0,0,0,32'h0,32'd0));
      vecs.push_back(mk(0,1,1,1,4'hF,32'h4,R5049,        32'h0, 1,0,32'h0, 0,0,0,R5049,32'd1));
      vecs.push_back(mk(0,1,1,1,4'hF,32'h0,32'h1,        R5050, 1,0,32'h0, 1,0,0,R5049,32'd1));
      vecs.push_back(mk(0,1,1,1,4'hF,32'h4,R5050,        R5050, 1,0,R5049, 1,0,0,R5049,32'd1));

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].start, vecs[i].req, vecs[i].we, vecs[i].be,
               vecs[i].addr, vecs[i].wdata, vecs[i].expected);
         tick();
         chk($sformatf("v%0d_rvalid", i),  {31'd0, rvalid_o},  {31'd0, vecs[i].rvalid});
         chk($sformatf("v%0d_err", i),     {31'd0, err_o},     {31'd0, vecs[i].err});
         chk($sformatf("v%0d_rdata", i),   rdata_o,            vecs[i].rdata);
         chk($sformatf("v%0d_done", i),    {31'd0, done_o},    {31'd0, vecs[i].done});
         chk($sformatf("v%0d_pass", i),    {31'd0, pass_o},    {31'd0, vecs[i].pass});
         chk($sformatf("v%0d_timeout", i), {31'd0, timeout_o}, {31'd0, vecs[i].timeout});
         chk($sformatf("v%0d_result", i),  result_o,           vecs[i].result);
         chk($sformatf("v%0d_cycles", i),  cycles_o,           vecs[i].cycles);
      end

      // Timeout: fires on the 16th edge after RUN entry with the counter frozen at 15.
      do_reset();
      idle_cycle();
      chk("to_entry_cycles", cycles_o, 32'd0);
      for (int k = 1; k <= 16; k++) begin
         idle_cycle();
         if (k == 16) begin
            chk("to_fire", {31'd0, timeout_o}, 32'd1);
            chk("to_cycles", cycles_o, 32'd15);
         end else begin
            chk($sformatf("to_early_%0d", k), {31'd0, timeout_o}, 32'd0);
         end
      end
      idle_cycle();
      chk("to_frozen", cycles_o, 32'd15);
      apply(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h1, 32'h0);
      tick();
      chk("to_flag_rvalid", {31'd0, rvalid_o}, 32'd1);
      chk("to_flag_done", {31'd0, done_o}, 32'd0);
      chk("to_flag_timeout", {31'd0, timeout_o}, 32'd1);

      // Completing FLAG write on the cycle the counter reaches TIMEOUT_CYCLES-1.
      do_reset();
      idle_cycle();
      for (int k = 1; k <= 15; k++) idle_cycle();
      chk("sim_pre_cycles", cycles_o, 32'd15);
      chk("sim_pre_timeout", {31'd0, timeout_o}, 32'd0);
      apply(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h1, 32'h0);
      tick();
      chk("sim_done", {31'd0, done_o}, 32'd1);
      chk("sim_timeout", {31'd0, timeout_o}, 32'd0);
      chk("sim_pass", {31'd0, pass_o}, 32'd1);
      chk("sim_cycles", cycles_o, 32'd15);

      // Reset on the cycle after a granted read drops the response.
      apply(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'hC, 32'h0, 32'h0);
      tick();
      chk("rst_pre_rvalid", {31'd0, rvalid_o}, 32'd1);
      chk("rst_pre_rdata", rdata_o, ID_VAL);
      @(negedge clk);
      rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; start_i = 1'b0;
      #1;
      chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      chk("rst_flags", {28'd0, err_o, done_o, pass_o, timeout_o}, 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_cycles", cycles_o, 32'd0);
      tick();
      chk("rst_post_rvalid", {31'd0, rvalid_o}, 32'd0);
      chk("rst_post_done", {31'd0, done_o}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
